// File: rtl/pulse_sync_pkg.sv
// rtl/pulse_sync_pkg.sv - shared state enum and parameter defaults for pulse_sync_mc
package pulse_sync_pkg;

   // Tx-side handshake state per channel
   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } tx_state_e;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_STAGES = 2;
   localparam int DEF_CNT_W  = 3;

endpackage

// File: rtl/pulse_sync_ch.sv
// rtl/pulse_sync_ch.sv - one toggle-handshake pulse channel with pending counter
module pulse_sync_ch
   import pulse_sync_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             i_clk_tx,
   input  logic             i_clk_rx,
   input  logic             i_rst_n,
   input  logic             i_pulse,
   input  logic             i_clr_ovf,
   output logic             o_pulse,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pend_cnt,
   output logic             o_overflow
);

   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

   tx_state_e         state_q, state_d;
   logic              req_tgl_q, req_tgl_d;
   logic [CNT_W-1:0]  pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              ovf_set;
   logic [STAGES-1:0] ack_sync_q;
   logic [STAGES-1:0] req_sync_q;
   logic              ack_tgl_q;
   logic              pulse_q;
   logic              done;

   // The rx side echoes every req toggle; equality means the last launch landed
   assign done = (ack_sync_q[STAGES-1] == req_tgl_q);

   // Tx state register, toggle, counter, sticky flag and ack synchroniser
   always_ff @(posedge i_clk_tx or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         req_tgl_q  <= 1'b0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
         ack_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         req_tgl_q  <= req_tgl_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         ack_sync_q <= {ack_sync_q[STAGES-2:0], ack_tgl_q};
      end
   end

   // Next state: launch, relaunch from backlog, or queue/drop incoming events
   always_comb begin
      state_d   = state_q;
      req_tgl_d = req_tgl_q;
      pend_d    = pend_q;
      ovf_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_pulse) begin
               req_tgl_d = ~req_tgl_q;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (done) begin
               if ((pend_q == '0) && !i_pulse) begin
                  state_d = IDLE;
               end else begin
                  // A new event arriving with the relaunch takes the freed slot
                  req_tgl_d = ~req_tgl_q;
                  if ((pend_q != '0) && !i_pulse) begin
                     pend_d = pend_q - PEND_ONE;
                  end
               end
            end else if (i_pulse) begin
               if (pend_q == PEND_MAX) begin
                  ovf_set = 1'b1;
               end else begin
                  pend_d = pend_q + PEND_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ovf_d = ovf_set | (ovf_q & ~i_clr_ovf);
   end

   // Outputs decoded from tx/rx registers
   always_comb begin
      o_busy     = (state_q == WAIT_ACK);
      o_pend_cnt = pend_q;
      o_overflow = ovf_q;
      o_pulse    = pulse_q;
   end

   // Rx synchroniser, ack toggle and one-cycle pulse on each observed edge
   always_ff @(posedge i_clk_rx or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_sync_q <= '0;
         ack_tgl_q  <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[STAGES-2:0], req_tgl_q};
         ack_tgl_q  <= req_sync_q[STAGES-1];
         pulse_q    <= req_sync_q[STAGES-1] ^ ack_tgl_q;
      end
   end

endmodule

// File: rtl/pulse_sync_mc.sv
// rtl/pulse_sync_mc.sv - multi-channel tx-to-rx pulse synchroniser
module pulse_sync_mc
   import pulse_sync_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int STAGES = DEF_STAGES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    i_clk_tx,
   input  logic                    i_clk_rx,
   input  logic                    i_rst_n,
   input  logic [NUM_CH-1:0]       i_pulse,
   input  logic [NUM_CH-1:0]       i_clr_ovf,
   output logic [NUM_CH-1:0]       o_pulse,
   output logic [NUM_CH-1:0]       o_busy,
   output logic [NUM_CH*CNT_W-1:0] o_pend_cnt,
   output logic [NUM_CH-1:0]       o_overflow
);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pulse_sync_ch #(
         .STAGES (STAGES),
         .CNT_W  (CNT_W)
      ) u_ch (
         .i_clk_tx   (i_clk_tx),
         .i_clk_rx   (i_clk_rx),
         .i_rst_n    (i_rst_n),
         .i_pulse    (i_pulse[k]),
         .i_clr_ovf  (i_clr_ovf[k]),
         .o_pulse    (o_pulse[k]),
         .o_busy     (o_busy[k]),
         .o_pend_cnt (o_pend_cnt[k*CNT_W +: CNT_W]),
         .o_overflow (o_overflow[k])
      );
   end

endmodule

// File: tb/tb_pulse_sync_mc.sv
// tb/tb_pulse_sync_mc.sv - directed and random scoreboard bench for pulse_sync_mc
`timescale 1ns/1ps
module tb_pulse_sync_mc;

   localparam int NCH = 2;
   localparam int CW  = 2;

   logic           clk_tx = 1'b0;
   logic           clk_rx = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] pulse_in;
   logic [NCH-1:0] clr_ovf;
   logic [NCH-1:0] pulse_out;
   logic [NCH-1:0] busy;
   logic [NCH*CW-1:0] pend;
   logic [NCH-1:0] ovf;

   realtime tx_half = 5.0;
   realtime rx_half = 13.5;

   int n_cmp = 0;
   int n_err = 0;
   int rx_edges = 0;
   int rx_cnt [NCH];
   int launch_edge [NCH];
   int last_lat [NCH];
   int q0 [$];
   int q1 [$];

   pulse_sync_mc #(.NUM_CH(NCH), .STAGES(2), .CNT_W(CW)) dut (
      .i_clk_tx   (clk_tx),
      .i_clk_rx   (clk_rx),
      .i_rst_n    (rst_n),
      .i_pulse    (pulse_in),
      .i_clr_ovf  (clr_ovf),
      .o_pulse    (pulse_out),
      .o_busy     (busy),
      .o_pend_cnt (pend),
      .o_overflow (ovf)
   );

   always #(tx_half) clk_tx = ~clk_tx;
   always #(rx_half) clk_rx = ~clk_rx;

   always @(posedge clk_rx) rx_edges <= rx_edges + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ch, input int v);
      if (ch == 0) q0.push_back(v);
      else q1.push_back(v);
   endtask

   // Scoreboard: every rx pulse must consume one expected event
   always @(negedge clk_rx) begin
      for (int c = 0; c < NCH; c++) begin
         if (pulse_out[c] === 1'b1) begin
            int sz;
            sz = (c == 0) ? q0.size() : q1.size();
            n_cmp++;
            assert (sz > 0) else begin
               n_err++;
               $error("FAIL rx_unexpected_ch%0d: observed o_pulse with %0d queued, expected >0", c, sz);
            end
            if (sz > 0) begin
               if (c == 0) void'(q0.pop_front());
               else void'(q1.pop_front());
            end
            rx_cnt[c]++;
            last_lat[c] = rx_edges - launch_edge[c];
         end
      end
   end

   task automatic wait_idle(input int ch, input string tag);
      int i;
      i = 0;
      while (busy[ch] !== 1'b0 && i < 500) begin
         @(negedge clk_tx);
         i++;
      end
      check(tag, 32'(busy[ch]), 32'd0);
      repeat (6) @(negedge clk_rx);
      @(negedge clk_tx);
   endtask

   // Bring tx to a fixed phase with the 10/27 ns clocks (common period 270 ns)
   task automatic align();
      @(negedge clk_tx);
      while ((int'($realtime) % 270) != 0) @(negedge clk_tx);
   endtask

   initial begin
      int k;
      int base0, base1;
      int sent [NCH];
      int gap [NCH];
      rx_cnt      = '{default: 0};
      launch_edge = '{default: 0};
      last_lat    = '{default: 0};
      rst_n    = 1'b0;
      pulse_in = '0;
      clr_ovf  = '0;
      #30;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pend", 32'(pend), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_pulse", 32'(pulse_out), 32'd0);
      @(negedge clk_tx);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_tx);

      // Single pulse on ch0
      pulse_in = 2'b01;
      push(0, 1);
      @(posedge clk_tx);
      launch_edge[0] = rx_edges;
      @(negedge clk_tx);
      pulse_in = '0;
      check("single_busy_set", 32'(busy), 32'd1);
      wait_idle(0, "single_busy_clr");
      check("single_rx_cnt", 32'(rx_cnt[0]), 32'd1);
      check("single_latency_3to4", 32'(last_lat[0] >= 3 && last_lat[0] <= 4), 32'd1);
      check("single_ch1_idle", 32'(busy[1]), 32'd0);
      check("single_ch1_cnt", 32'(rx_cnt[1]), 32'd0);

      // Find the completion edge of a lone handshake at a fixed clock phase
      align();
      pulse_in = 2'b01;
      push(0, 2);
      @(negedge clk_tx);
      pulse_in = '0;
      k = 1;
      while (busy[0] !== 1'b0 && k < 400) begin
         @(negedge clk_tx);
         k++;
      end
      repeat (6) @(negedge clk_rx);
      base0 = rx_cnt[0];
      // Same phase again, with a second pulse landing on the completion edge
      align();
      pulse_in = 2'b01;
      push(0, 3);
      @(negedge clk_tx);
      pulse_in = '0;
      repeat (k - 2) @(negedge clk_tx);
      pulse_in = 2'b01;
      push(0, 4);
      @(negedge clk_tx);
      pulse_in = '0;
      check("coinc_busy_stays", 32'(busy[0]), 32'd1);
      check("coinc_pend_zero", 32'(pend[1:0]), 32'd0);
      wait_idle(0, "coinc_idle");
      check("coinc_rx_two", 32'(rx_cnt[0] - base0), 32'd2);

      // Five back-to-back pulses saturate the counter and overflow on the fifth
      base0 = rx_cnt[0];
      for (int i = 0; i < 5; i++) begin
         pulse_in = 2'b01;
         if (i < 4) push(0, 10 + i);
         @(negedge clk_tx);
         check($sformatf("b2b_pend_%0d", i), 32'(pend[1:0]), 32'((i < 3) ? i : 3));
         check($sformatf("b2b_ovf_%0d", i), 32'(ovf[0]), 32'(i == 4));
      end
      pulse_in = '0;
      wait_idle(0, "b2b_idle");
      check("b2b_rx_four", 32'(rx_cnt[0] - base0), 32'd4);
      check("b2b_ovf_sticky", 32'(ovf[0]), 32'd1);
      check("b2b_queue_empty", 32'(q0.size()), 32'd0);

      // Clear, then overflow again with a coincident clear (set wins)
      clr_ovf = 2'b01;
      @(negedge clk_tx);
      clr_ovf = '0;
      check("clr_ovf_plain", 32'(ovf[0]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         pulse_in = 2'b01;
         clr_ovf  = (i == 4) ? 2'b01 : 2'b00;
         if (i < 4) push(0, 20 + i);
         @(negedge clk_tx);
      end
      pulse_in = '0;
      clr_ovf  = 2'b01;
      check("clr_vs_set", 32'(ovf[0]), 32'd1);
      @(negedge clk_tx);
      clr_ovf = '0;
      check("clr_next_cycle", 32'(ovf[0]), 32'd0);
      wait_idle(0, "clr_idle");
      check("clr_queue_empty", 32'(q0.size()), 32'd0);

      // Reset with a handshake in flight and two events pending
      for (int i = 0; i < 3; i++) begin
         pulse_in = 2'b01;
         @(negedge clk_tx);
      end
      pulse_in = '0;
      check("rst_pre_busy", 32'(busy[0]), 32'd1);
      check("rst_pre_pend", 32'(pend[1:0]), 32'd2);
      base0 = rx_cnt[0];
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_pulse", 32'(pulse_out), 32'd0);
      repeat (3) @(negedge clk_tx);
      rst_n = 1'b1;
      repeat (40) @(negedge clk_tx);
      check("rst_no_pulse", 32'(rx_cnt[0] - base0), 32'd0);
      check("rst_still_idle", 32'(busy), 32'd0);

      // Swap clock ratio: slow tx, fast rx, random traffic on both channels
      tx_half = 25.0;
      rx_half = 3.333;
      repeat (4) @(negedge clk_tx);
      base0 = rx_cnt[0];
      base1 = rx_cnt[1];
      sent = '{default: 0};
      gap  = '{default: 0};
      while (sent[0] < 100 || sent[1] < 100) begin
         for (int c = 0; c < NCH; c++) begin
            if (gap[c] == 0 && sent[c] < 100) begin
               pulse_in[c] = 1'b1;
               sent[c]++;
               push(c, sent[c]);
               gap[c] = $urandom_range(6, 2);
            end else begin
               pulse_in[c] = 1'b0;
               if (gap[c] > 0) gap[c]--;
            end
         end
         @(negedge clk_tx);
      end
      pulse_in = '0;
      wait_idle(0, "rand_idle0");
      wait_idle(1, "rand_idle1");
      check("rand_rx_ch0", 32'(rx_cnt[0] - base0), 32'd100);
      check("rand_rx_ch1", 32'(rx_cnt[1] - base1), 32'd100);
      check("rand_ovf", 32'(ovf), 32'd0);
      check("rand_q0_empty", 32'(q0.size()), 32'd0);
      check("rand_q1_empty", 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
